lc3_pipe_ctrl_p: RTL

- Parametrised next-generation LC-3 pipeline controller (fetch/decode/execute/writeback).
- Generates stage enables, branch resolution and operand-forwarding selects.
- Memory-access FSM is now registered, with a programmable timeout and a sticky error flag.
- Branch bubble depth is configurable.
- Sits beside the datapath, driven by the decode-stage IR, the execute-stage IR_Exec, the fetched IMem_dout and the memory handshake.

---
 rtl/lc3_pipe_ctrl_p_if.sv | 49 ++++
 rtl/lc3_pipe_ctrl_p.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_pipe_ctrl_p_if.sv
// lc3_pipe_ctrl_p_if: bundles the pipeline-controller handshake and status signals.
//   slave  modport: the controller (consumes IRs/memory handshake, drives enables/bypass/status).
//   master modport: the datapath side (drives IRs/memory handshake, observes controller outputs).
// Optional writeback-stage forwarding outputs exist only when LC3_WB_FWD_EN is defined.
interface lc3_pipe_ctrl_p_if;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [15:0] IMem_dout;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;
  logic        mem_timeout;
`ifdef LC3_WB_FWD_EN
  logic        bypass_wb_1;
  logic        bypass_wb_2;
`endif

  modport slave (
    input  complete_data, complete_instr, IR, IR_Exec, IMem_dout, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state, mem_timeout
`ifdef LC3_WB_FWD_EN
    , output bypass_wb_1, bypass_wb_2
`endif
  );

  modport master (
    output complete_data, complete_instr, IR, IR_Exec, IMem_dout, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state, mem_timeout
`ifdef LC3_WB_FWD_EN
    , input bypass_wb_1, bypass_wb_2
`endif
  );
endinterface

// File: rtl/lc3_pipe_ctrl_p.sv
// lc3_pipe_ctrl_p: LC-3 pipeline controller (stage enables, branch redirect, operand forwarding, memory FSM).
// Latency: enables/mem_state/mem_timeout registered (1 cycle); fetch enable, br_taken and bypass selects combinational.
// Backpressure: a pending data-memory access stalls the whole pipe until complete_data or timeout abort.
// Ports: clk, rst (sync, active high); bus (slave modport of lc3_pipe_ctrl_p_if) carries IR/IR_Exec/IMem_dout,
//   NZP/psr, complete_data/complete_instr in, and stage enables, br_taken, bypass_*, mem_state, mem_timeout out.
// Optional: define LC3_WB_FWD_EN to add a writeback-stage IR register and bypass_wb_1/bypass_wb_2.
module lc3_pipe_ctrl_p #(
  parameter int BR_BUBBLES  = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input  logic             clk,
  input  logic             rst,
  lc3_pipe_ctrl_p_if.slave bus
);

  typedef enum logic [1:0] {
    MS_RD     = 2'd0,
    MS_IND_RD = 2'd1,
    MS_WR     = 2'd2,
    MS_IDLE   = 2'd3
  } mem_state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // State
  mem_state_e    mem_state_q, mem_state_d;
  logic [TW-1:0] mem_cnt_q, mem_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;
  logic [2:0]    bub_q, bub_d;
  logic          en_dec_q, en_dec_d;
  logic          en_exe_q, en_exe_d;
  logic          en_wb_q, en_wb_d;

  // Opcode decode
  logic [3:0] ex_op, id_op, if_op;
  logic       ex_alu, ex_ldc, ex_mem, ex_nowb, id_alu, if_ctl;

  assign ex_op = bus.IR_Exec[15:12];
  assign id_op = bus.IR[15:12];
  assign if_op = bus.IMem_dout[15:12];

  assign ex_alu  = ex_op inside {OP_ADD, OP_AND, OP_NOT};
  assign ex_ldc  = ex_op inside {OP_LD, OP_LDR, OP_LDI, OP_LEA};
  assign ex_mem  = ex_op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
  assign ex_nowb = ex_op inside {OP_BR, OP_JMP, OP_ST, OP_STR, OP_STI};
  assign id_alu  = id_op inside {OP_ADD, OP_AND, OP_NOT};
  assign if_ctl  = if_op inside {OP_BR, OP_JMP};

  // Stall / fetch / branch
  logic mem_busy, mem_done, mem_abort, stall, fetch_ok, br_int;

  assign mem_busy  = (mem_state_q != MS_IDLE);
  assign mem_done  = ((mem_state_q == MS_RD) || (mem_state_q == MS_WR)) && bus.complete_data;
  // Abort fires on the cycle the counter would reach MEM_TIMEOUT, so a state lasts at most MEM_TIMEOUT cycles.
  assign mem_abort = mem_busy && !bus.complete_data && (mem_cnt_q == TW'(MEM_TIMEOUT - 1));
  assign stall     = en_exe_q && ex_mem && !mem_done && !mem_abort;
  assign fetch_ok  = !stall && (bub_q == 3'd0) && bus.complete_instr;
  assign br_int    = en_exe_q && ((ex_op == OP_JMP) ||
                                  ((ex_op == OP_BR) && (|(bus.NZP & bus.psr))));

  // Memory FSM next state
  always_comb begin
    mem_state_d   = mem_state_q;
    mem_cnt_d     = mem_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (mem_state_q == MS_IDLE) begin
      mem_cnt_d = '0;
      if (en_exe_q && ex_mem) begin
        case (ex_op)
          OP_LD, OP_LDR: mem_state_d = MS_RD;
          OP_ST, OP_STR: mem_state_d = MS_WR;
          default:       mem_state_d = MS_IND_RD;
        endcase
      end
    end else if (bus.complete_data) begin
      mem_cnt_d = '0;
      if (mem_state_q == MS_IND_RD) begin
        // Opcode bit 12 separates STI (1011) from LDI (1010).
        mem_state_d = bus.IR_Exec[12] ? MS_WR : MS_RD;
      end else begin
        mem_state_d = MS_IDLE;
      end
    end else if (mem_abort) begin
      mem_state_d   = MS_IDLE;
      mem_cnt_d     = '0;
      mem_timeout_d = 1'b1;
    end else begin
      mem_cnt_d = mem_cnt_q + TW'(1);
    end
  end

  // Bubble counter and enable chain
  always_comb begin
    bub_d    = bub_q;
    en_dec_d = en_dec_q;
    en_exe_d = en_exe_q;
    en_wb_d  = en_wb_q;
    // A taken redirect squashes the remaining bubble; wrong-path CTL fetches are ignored.
    if (br_int) begin
      bub_d = 3'd0;
    end else if (fetch_ok && if_ctl) begin
      bub_d = 3'(BR_BUBBLES);
    end else if (!stall && (bub_q != 3'd0)) begin
      bub_d = bub_q - 3'd1;
    end
    if (!stall) begin
      en_dec_d = fetch_ok;
      en_exe_d = en_dec_q;
      en_wb_d  = en_exe_q && !ex_nowb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_state_q   <= MS_IDLE;
      mem_cnt_q     <= '0;
      mem_timeout_q <= 1'b0;
      bub_q         <= 3'd0;
      en_dec_q      <= 1'b0;
      en_exe_q      <= 1'b0;
      en_wb_q       <= 1'b0;
    end else begin
      mem_state_q   <= mem_state_d;
      mem_cnt_q     <= mem_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      bub_q         <= bub_d;
      en_dec_q      <= en_dec_d;
      en_exe_q      <= en_exe_d;
      en_wb_q       <= en_wb_d;
    end
  end

  // Forwarding
  logic       fwd_gate, op1_used, op2_used, m1_ex, m2_ex;
  logic [2:0] src1, src2;
  logic       alu1, alu2, mem1, mem2;

  assign fwd_gate = en_dec_q && en_exe_q;
  assign op1_used = id_alu || (id_op inside {OP_STR, OP_LDR, OP_JMP});
  assign op2_used = ((id_op inside {OP_ADD, OP_AND}) && !bus.IR[5]) ||
                    (id_op inside {OP_ST, OP_STI, OP_STR});
  assign src1     = bus.IR[8:6];
  assign src2     = (id_op inside {OP_ADD, OP_AND}) ? bus.IR[2:0] : bus.IR[11:9];
  assign m1_ex    = op1_used && (src1 == bus.IR_Exec[11:9]);
  assign m2_ex    = op2_used && (src2 == bus.IR_Exec[11:9]);
  assign alu1     = fwd_gate && ex_alu && m1_ex;
  assign alu2     = fwd_gate && ex_alu && m2_ex;
  assign mem1     = fwd_gate && ex_ldc && m1_ex;
  assign mem2     = fwd_gate && ex_ldc && m2_ex;

  // Outputs; combinational ones are held low during reset
  assign bus.enable_fetch     = !rst && fetch_ok;
  assign bus.enable_updatePC  = !rst && fetch_ok;
  assign bus.enable_decode    = en_dec_q;
  assign bus.enable_execute   = en_exe_q;
  assign bus.enable_writeback = en_wb_q;
  assign bus.br_taken         = !rst && br_int;
  assign bus.bypass_alu_1     = !rst && alu1;
  assign bus.bypass_alu_2     = !rst && alu2;
  assign bus.bypass_mem_1     = !rst && mem1;
  assign bus.bypass_mem_2     = !rst && mem2;
  assign bus.mem_state        = mem_state_q;
  assign bus.mem_timeout      = mem_timeout_q;

`ifdef LC3_WB_FWD_EN
  logic [15:0] ir_wb_q, ir_wb_d;
  logic [3:0]  wb_op;
  logic        wb_gate;

  // Track the instruction that moves into writeback alongside its enable.
  always_comb begin
    ir_wb_d = ir_wb_q;
    if (!stall && en_exe_q) begin
      ir_wb_d = bus.IR_Exec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_wb_q <= 16'h0000;
    end else begin
      ir_wb_q <= ir_wb_d;
    end
  end

  assign wb_op   = ir_wb_q[15:12];
  assign wb_gate = en_dec_q && en_wb_q &&
                   (wb_op inside {OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA});
  // Exec-stage forwarding holds the younger result, so it wins over writeback.
  assign bus.bypass_wb_1 = !rst && wb_gate && op1_used && (src1 == ir_wb_q[11:9]) && !(alu1 || mem1);
  assign bus.bypass_wb_2 = !rst && wb_gate && op2_used && (src2 == ir_wb_q[11:9]) && !(alu2 || mem2);

  logic unused_wb_bits;
  assign unused_wb_bits = ^ir_wb_q[8:0];
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.IR[4:3], bus.IR_Exec[8:0], bus.IMem_dout[11:0]};

endmodule
